// File: rtl/mpu_det_seq_pkg.sv
// Shared definitions for the sequential Leibniz determinant unit:
// FSM state encoding, default widths and constant helper functions.
package mpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_MAX_N  = 5;
    localparam int DEF_ACC_W  = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_ENUM,
        S_DONE
    } mpu_state_e;

    function automatic int fact(input int n);
        int r;
        r = 1;
        for (int i = 2; i <= n; i++) begin
            r = r * i;
        end
        return r;
    endfunction

    // Address width that stays legal for a 1x1 register file.
    function automatic int addr_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mpu_det_seq_if.sv
// Bus bundle of the determinant unit: element writes, start/size request
// and the busy/done/determinant/err result. master drives, slave computes.
interface mpu_det_seq_if
    import mpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAX_N  = DEF_MAX_N,
    parameter int ACC_W  = DEF_ACC_W
);
    localparam int AW = addr_w(MAX_N);

    logic                     wr_en;
    logic [AW-1:0]            wr_row;
    logic [AW-1:0]            wr_col;
    logic signed [DATA_W-1:0] wr_data;
    logic                     start;
    logic [7:0]               size;
    logic                     busy;
    logic                     done;
    logic signed [ACC_W-1:0]  determinant;
    logic                     err;

    modport master (
        output wr_en, wr_row, wr_col, wr_data, start, size,
        input  busy, done, determinant, err
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_data, start, size,
        output busy, done, determinant, err
    );

endinterface

// File: rtl/mpu_det_seq_perm_gen.sv
// Heap's-algorithm permutation generator, one permutation per step.
// Ports: i_init (identity, even), i_step, i_n order; o_perm, o_parity, o_last.
module mpu_perm_gen
    import mpu_pkg::*;
#(
    parameter int MAX_N = DEF_MAX_N,
    parameter int AW    = addr_w(MAX_N)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_init,
    input  logic                          i_step,
    input  logic [7:0]                    i_n,
    output logic [MAX_N-1:0][AW-1:0]      o_perm,
    output logic                          o_parity,
    output logic                          o_last
);

    logic [MAX_N-1:0][AW-1:0] r_perm;
    logic [AW-1:0]            r_c [MAX_N];
    logic                     r_parity;

    logic          w_found;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_a;

    // The iterative Heap loop skips (and zeroes) every counter that has
    // run out; the next swap position is therefore the lowest i with
    // c[i] < i, which lets each step finish in a single cycle.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i < MAX_N; i++) begin
            if (!w_found && i < int'(i_n) && int'(r_c[i]) < i) begin
                w_found = 1'b1;
                w_idx   = AW'(i);
            end
        end
        w_a = w_idx[0] ? r_c[w_idx] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < MAX_N; j++) begin
                r_perm[j] <= AW'(j);
                r_c[j]    <= '0;
            end
            r_parity <= 1'b0;
        end else if (i_init) begin
            for (int j = 0; j < MAX_N; j++) begin
                r_perm[j] <= AW'(j);
                r_c[j]    <= '0;
            end
            r_parity <= 1'b0;
        end else if (i_step && w_found) begin
            for (int j = 0; j < MAX_N; j++) begin
                if (j < int'(w_idx)) begin
                    r_c[j] <= '0;
                end
            end
            r_c[w_idx]    <= r_c[w_idx] + AW'(1);
            r_perm[w_a]   <= r_perm[w_idx];
            r_perm[w_idx] <= r_perm[w_a];
            r_parity      <= ~r_parity;
        end
    end

    assign o_perm   = r_perm;
    assign o_parity = r_parity;
    assign o_last   = !w_found;

endmodule

// File: rtl/mpu_det_seq.sv
// Sequential determinant unit: element register file plus Leibniz sum,
// one signed permutation product per cycle. Ports: clk, rst_n, bus (slave).
module mpu_det_seq
    import mpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAX_N  = DEF_MAX_N,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic        clk,
    input  logic        rst_n,
    mpu_det_seq_if.slave bus
);

    localparam int AW = addr_w(MAX_N);
    localparam int PW = DATA_W * MAX_N;

    logic signed [DATA_W-1:0] r_mat [MAX_N][MAX_N];
    mpu_state_e               r_state;
    logic [7:0]               r_n;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_det;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;

    logic [MAX_N-1:0][AW-1:0] w_perm;
    logic                     w_parity;
    logic                     w_last;
    logic                     w_init;
    logic                     w_step;
    logic                     w_n_ok;
    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  w_acc_next;

    assign w_init = (r_state == S_INIT);
    assign w_step = (r_state == S_ENUM) && !w_last;
    assign w_n_ok = (r_n != 8'd0) && (int'(r_n) <= MAX_N);

    mpu_perm_gen #(
        .MAX_N (MAX_N),
        .AW    (AW)
    ) u_perm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_init   (w_init),
        .i_step   (w_step),
        .i_n      (r_n),
        .o_perm   (w_perm),
        .o_parity (w_parity),
        .o_last   (w_last)
    );

    // Rows at or beyond n are skipped, so unused elements never feed
    // the product; the full-width product wraps before resizing.
    always_comb begin
        w_prod = {{(PW-1){1'b0}}, 1'b1};
        for (int k = 0; k < MAX_N; k++) begin
            if (k < int'(r_n)) begin
                w_prod = w_prod * PW'(r_mat[k][w_perm[k]]);
            end
        end
        w_term     = ACC_W'(w_prod);
        w_acc_next = w_parity ? (r_acc - w_term) : (r_acc + w_term);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < MAX_N; r++) begin
                for (int c = 0; c < MAX_N; c++) begin
                    r_mat[r][c] <= '0;
                end
            end
        end else if (bus.wr_en && !r_busy
                     && int'(bus.wr_row) < MAX_N
                     && int'(bus.wr_col) < MAX_N) begin
            r_mat[bus.wr_row][bus.wr_col] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_acc   <= '0;
            r_det   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_n     <= bus.size;
                        r_busy  <= 1'b1;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_acc <= '0;
                    if (w_n_ok) begin
                        r_state <= S_ENUM;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_det   <= '0;
                    end
                end
                S_ENUM: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_det   <= w_acc_next;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.determinant = r_det;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_mpu_det_seq.sv
// Directed bench for mpu_det_seq: hand-computed determinants, done
// latency, invalid sizes, busy masking and asynchronous reset.
module tb_mpu_det_seq;
    import mpu_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   misses;

    mpu_det_seq_if #(.DATA_W(8), .MAX_N(5), .ACC_W(32)) bus ();

    mpu_det_seq #(.DATA_W(8), .MAX_N(5), .ACC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int r, input int c, input int d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_row  = 3'(r);
        bus.wr_col  = 3'(c);
        bus.wr_data = 8'(d);
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts edges after the accepting edge until done is seen.
    task automatic wait_done(input int c0, output int cnt);
        logic seen;
        seen = 1'b0;
        cnt  = c0;
        if (bus.done) seen = 1'b1;
        while (!seen && cnt < 2000) begin
            @(posedge clk);
            cnt++;
            #1;
            if (bus.done) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'(1));
    endtask

    task automatic finish_chk(input string tag, input int cnt,
                              input int exp_edge,
                              input logic signed [31:0] exp_det,
                              input logic exp_err);
        chk({tag, "_edge"}, 64'(cnt + 1), 64'(exp_edge));
        chk({tag, "_det"}, 64'(bus.determinant), 64'(exp_det));
        chk({tag, "_err"}, 64'(bus.err), 64'(exp_err));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(bus.done), 64'(0));
        chk({tag, "_idle"}, 64'(bus.busy), 64'(0));
    endtask

    task automatic run(input string tag, input int n,
                       input logic signed [31:0] exp_det,
                       input logic exp_err, input int exp_edge);
        int cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.size  = 8'(n);
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, "_busy0"}, 64'(bus.busy), 64'(1));
        wait_done(0, cnt);
        finish_chk(tag, cnt, exp_edge, exp_det, exp_err);
    endtask

    initial begin
        int  cnt;
        logic saw_done;
        vectors     = 0;
        misses      = 0;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_row  = '0;
        bus.wr_col  = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.size    = '0;
        #12;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        chk("rst_det", 64'(bus.determinant), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        wr(0, 0, -7);
        run("n1", 1, -7, 1'b0, 3);

        wr(0, 0, 3); wr(0, 1, 8);
        wr(1, 0, 4); wr(1, 1, 6);
        run("n2", 2, -14, 1'b0, 4);

        wr(0, 0, 6); wr(0, 1, 1);  wr(0, 2, 1);
        wr(1, 0, 4); wr(1, 1, -2); wr(1, 2, 5);
        wr(2, 0, 2); wr(2, 1, 8);  wr(2, 2, 7);
        run("n3", 3, -306, 1'b0, 8);

        do_reset();
        for (int k = 0; k < 5; k++) wr(k, k, 2);
        run("diag5", 5, 32, 1'b0, 122);
        wr(0, 0, 0); wr(0, 1, 2);
        wr(1, 0, 2); wr(1, 1, 0);
        run("swap5", 5, -32, 1'b0, 122);

        run("size0", 0, 0, 1'b1, 2);
        run("size6", 6, 0, 1'b1, 2);

        // start and a write while busy must both be dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.size  = 8'd2;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.size    = 8'd1;
        bus.wr_en   = 1'b1;
        bus.wr_row  = 3'd0;
        bus.wr_col  = 3'd0;
        bus.wr_data = 8'sd9;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        wait_done(2, cnt);
        finish_chk("busyign", cnt, 4, -4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("noqueue", 64'(bus.busy), 64'(0));
        run("nowrite", 1, 0, 1'b0, 3);

        // write and start together: the new value is used
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_row  = 3'd0;
        bus.wr_col  = 3'd0;
        bus.wr_data = -8'sd3;
        bus.start   = 1'b1;
        bus.size    = 8'd1;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        wait_done(0, cnt);
        finish_chk("wrstart", cnt, 3, -3, 1'b0);

        // asynchronous reset in the middle of an n=4 enumeration
        @(negedge clk);
        bus.start = 1'b1;
        bus.size  = 8'd4;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'(0));
        chk("arst_det", 64'(bus.determinant), 64'(0));
        chk("arst_done", 64'(bus.done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("arst_nodone", 64'(saw_done), 64'(0));
        wr(0, 0, 3); wr(0, 1, 8);
        wr(1, 0, 4); wr(1, 1, 6);
        run("rerun2", 2, -14, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, misses);
        $finish;
    end

endmodule

// File: doc/mpu_det_seq.md
MPU_DET_SEQ -- requirements
Module: mpu_det_seq

Interface
REQ-001 Parameter DATA_W, default 8, signed element width (two's complement).
REQ-002 Parameter MAX_N, default 5, largest supported matrix order (1..6).
REQ-003 Parameter ACC_W, default 32, determinant/accumulator width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 wr_en  in  1  element write strobe.
REQ-007 wr_row, wr_col  in  clog2(MAX_N) each  element address.
REQ-008 wr_data  in  DATA_W  element value.
REQ-009 start  in  1  start request; sampled only in IDLE.
REQ-010 size  in  8  matrix order n, captured with accepted start.
REQ-011 busy  out  1  high from accepted start until done cycle inclusive.
REQ-012 done  out  1  single-cycle completion pulse.
REQ-013 determinant  out  ACC_W  signed result, held until next accepted start.
REQ-014 err  out  1  invalid size flag, valid with done, held like determinant.

Function
REQ-015 Internal MAX_N x MAX_N element register file; write takes effect at the edge with wr_en high; writes with busy high or address >= MAX_N are ignored.
REQ-016 States: IDLE, INIT, ENUM, DONE; IDLE->INIT on start; INIT->ENUM if 1<=n<=MAX_N else INIT->DONE with err=1, determinant=0; ENUM->DONE after last permutation; DONE->IDLE unconditionally.
REQ-017 Determinant computed by Leibniz expansion: one permutation of columns 0..n-1 per ENUM cycle, enumerated by Heap's algorithm; parity toggles on every swap.
REQ-018 Each ENUM cycle adds (even) or subtracts (odd) the signed product of A[k][p[k]], k<n, into the accumulator; rows/columns >= n are never read.
REQ-019 Product formed at DATA_W*MAX_N bits signed, then sign-extended or truncated to ACC_W; accumulation wraps modulo 2^ACC_W, no saturation.
REQ-020 INIT clears accumulator, identity permutation, parity even, Heap counters zero.
REQ-021 ENUM lasts exactly n! cycles; done is high for exactly one cycle, first sampled high at the (n!+2)th rising edge after the accepting edge; invalid size gives done at the 2nd edge.
REQ-022 determinant and err update in the same edge that raises done.
REQ-023 start while busy is ignored, not queued; start and wr_en in the same IDLE cycle: write lands and start uses the new value.
REQ-024 Matrix contents persist across operations; only writes change them.

Reset
REQ-025 rst_n low immediately forces IDLE, busy=0, done=0, err=0, determinant=0, accumulator and permutation state cleared; element registers cleared to 0.
REQ-026 Reset mid-ENUM abandons the operation with no done pulse; first start after release behaves as from power-up.

Structure
REQ-027 Package mpu_pkg holds state enum, default DATA_W/MAX_N/ACC_W constants, and a constant factorial function for bench latency checks.
REQ-028 One sub-module mpu_perm_gen: Heap's-algorithm permutation generator with init, step, order n inputs; perm vector, parity and last outputs.
REQ-029 Product/accumulate datapath stays in mpu_det_seq; no multicycle paths.

Verification
REQ-030 n=1, A00=-7 -> determinant=-7, err=0, done at 3rd edge.
REQ-031 n=2, [[3,8],[4,6]] -> -14, done at 4th edge.
REQ-032 n=3, [[6,1,1],[4,-2,5],[2,8,7]] -> -306, done at 8th edge.
REQ-033 n=5, diagonal 2, zeros elsewhere -> 32, done at 122nd edge; then n=5 with rows 0 and 1 swapped -> -32.
REQ-034 size=0 and size=6 -> err=1, determinant=0, done at 2nd edge; start during busy and wr_en during busy have no effect.
REQ-035 rst_n low in mid-ENUM of n=4 -> outputs zero asynchronously, no done; rerun n=2 test gives -14.
